// File: rtl/reg_writeback_pkg.sv
// Shared types and default sizes for the writeback stage.
// wb_src_e names the two result producers; used for the round-robin pointer.
package reg_writeback_pkg;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

  localparam int REG_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF = 4;

endpackage

// File: rtl/wb_rr_arb.sv
// 2-way round-robin arbiter for the writeback stage.
// Ports: clk/rst, alu_valid/ld_valid in; alu_ready/ld_ready, alu_grant/ld_grant, prio out.
module wb_rr_arb
  import reg_writeback_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    alu_valid,
  input  logic    ld_valid,
  output logic    alu_ready,
  output logic    ld_ready,
  output logic    alu_grant,
  output logic    ld_grant,
  output wb_src_e prio
);

  wb_src_e prio_next;

  // Readies never look at their own valid.
  assign alu_ready = !rst && (!ld_valid || prio == SRC_ALU);
  assign ld_ready  = !rst && (!alu_valid || prio == SRC_LD);

  assign alu_grant = alu_valid && alu_ready;
  assign ld_grant  = ld_valid && ld_ready;

  // The winner of any acceptance yields priority to the other side,
  // which also covers "move to the loser" under contention.
  always_comb begin
    prio_next = prio;
    if (alu_grant) begin
      prio_next = SRC_LD;
    end else if (ld_grant) begin
      prio_next = SRC_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= SRC_ALU;
    end else begin
      prio <= prio_next;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: arbitrates ALU/load results onto the regfile write port
// and tracks outstanding writes in a per-register pending scoreboard.
// Ports: i_clk, i_rst (sync, active-high); ALU and load valid/ready/addr/val;
// i_claim_en/i_claim_addr from issue; o_reg_addr_w/o_reg_val_w/o_write_en
// to the register file; o_pending scoreboard bits.
// Option: define REG_WRITEBACK_ZERO_REG_EN to hardwire register 0 to zero.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_alu_valid,
  output logic                     o_alu_ready,
  input  logic [ADDR_WIDTH-1:0]    i_alu_addr,
  input  logic [REG_WIDTH-1:0]     i_alu_val,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [ADDR_WIDTH-1:0]    i_ld_addr,
  input  logic [REG_WIDTH-1:0]     i_ld_val,
  input  logic                     i_claim_en,
  input  logic [ADDR_WIDTH-1:0]    i_claim_addr,
  output logic [ADDR_WIDTH-1:0]    o_reg_addr_w,
  output logic [REG_WIDTH-1:0]     o_reg_val_w,
  output logic                     o_write_en,
  output logic [2**ADDR_WIDTH-1:0] o_pending
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic            alu_grant;
  logic            ld_grant;
  wb_src_e         prio;

  logic                  acc;
  logic                  do_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [REG_WIDTH-1:0]  sel_val;

  logic [NUM_REGS-1:0] retire_mask;
  logic [NUM_REGS-1:0] claim_mask;
  logic [NUM_REGS-1:0] pending_next;

  wb_rr_arb u_arb (
    .clk       (i_clk),
    .rst       (i_rst),
    .alu_valid (i_alu_valid),
    .ld_valid  (i_ld_valid),
    .alu_ready (o_alu_ready),
    .ld_ready  (o_ld_ready),
    .alu_grant (alu_grant),
    .ld_grant  (ld_grant),
    .prio      (prio)
  );

  assign acc      = alu_grant || ld_grant;
  assign sel_addr = ld_grant ? i_ld_addr : i_alu_addr;
  assign sel_val  = ld_grant ? i_ld_val  : i_alu_val;

`ifdef REG_WRITEBACK_ZERO_REG_EN
  // Writes to r0 complete the handshake but are dropped here.
  assign do_write = acc && (sel_addr != '0);
`else
  assign do_write = acc;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_write_en   <= 1'b0;
      o_reg_addr_w <= '0;
      o_reg_val_w  <= '0;
    end else begin
      o_write_en <= do_write;
      if (do_write) begin
        o_reg_addr_w <= sel_addr;
        o_reg_val_w  <= sel_val;
      end
    end
  end

  // Claim is OR-ed in after the retire clear so a same-register
  // claim/retire collision leaves the bit set.
  always_comb begin
    retire_mask = '0;
    claim_mask  = '0;
    if (o_write_en) begin
      retire_mask[o_reg_addr_w] = 1'b1;
    end
    if (i_claim_en) begin
      claim_mask[i_claim_addr] = 1'b1;
    end
    pending_next = (o_pending & ~retire_mask) | claim_mask;
`ifdef REG_WRITEBACK_ZERO_REG_EN
    pending_next[0] = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pending <= '0;
    end else begin
      o_pending <= pending_next;
    end
  end

  logic unused_prio;
  assign unused_prio = prio;

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: reference model plus expected-write queue.
// Honours REG_WRITEBACK_ZERO_REG_EN when defined for the DUT as well.
module tb_reg_writeback;

  localparam int RW = 32;
  localparam int AW = 4;
  localparam int NR = 2**AW;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [RW-1:0] val;
  } wb_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, ld_valid, claim_en;
  logic          alu_ready, ld_ready;
  logic [AW-1:0] alu_addr, ld_addr, claim_addr;
  logic [RW-1:0] alu_val, ld_val;
  logic [AW-1:0] reg_addr_w;
  logic [RW-1:0] reg_val_w;
  logic          write_en;
  logic [NR-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  wb_exp_t exp_q[$];

  logic          m_prio = 1'b0;
  logic          m_we   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [NR-1:0] m_pend = '0;

`ifdef REG_WRITEBACK_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_writeback #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_alu_valid  (alu_valid),
    .o_alu_ready  (alu_ready),
    .i_alu_addr   (alu_addr),
    .i_alu_val    (alu_val),
    .i_ld_valid   (ld_valid),
    .o_ld_ready   (ld_ready),
    .i_ld_addr    (ld_addr),
    .i_ld_val     (ld_val),
    .i_claim_en   (claim_en),
    .i_claim_addr (claim_addr),
    .o_reg_addr_w (reg_addr_w),
    .o_reg_val_w  (reg_val_w),
    .o_write_en   (write_en),
    .o_pending    (pending)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r,
                     input logic av, input logic [AW-1:0] aa,
                     input logic [RW-1:0] avl,
                     input logic lv, input logic [AW-1:0] la,
                     input logic [RW-1:0] lvl,
                     input logic ce, input logic [AW-1:0] ca);
    logic    ar, lr, aacc, lacc;
    logic [NR-1:0] nx;
    wb_exp_t e, g;
    @(negedge clk);
    rst = r;
    alu_valid = av; alu_addr = aa; alu_val = avl;
    ld_valid = lv; ld_addr = la; ld_val = lvl;
    claim_en = ce; claim_addr = ca;
    #1;
    ar = !r && (!lv || m_prio == 1'b0);
    lr = !r && (!av || m_prio == 1'b1);
    chk("alu_ready", 64'(alu_ready), 64'(ar));
    chk("ld_ready", 64'(ld_ready), 64'(lr));
    aacc = av && ar;
    lacc = lv && lr;
    e.en   = 1'b0;
    e.addr = lacc ? la : aa;
    e.val  = lacc ? lvl : avl;
    if (!r && (aacc || lacc)) begin
      e.en = !(ZR && e.addr == '0);
    end
    exp_q.push_back(e);
    nx = m_pend;
    if (m_we) nx[m_addr] = 1'b0;
    if (ce) nx[ca] = 1'b1;
    if (ZR) nx[0] = 1'b0;
    if (r) nx = '0;
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    chk("write_en", 64'(write_en), 64'(g.en));
    if (g.en) begin
      chk("wr_addr", 64'(reg_addr_w), 64'(g.addr));
      chk("wr_val", 64'(reg_val_w), 64'(g.val));
    end
    chk("pending", 64'(pending), 64'(nx));
    m_pend = nx;
    m_we   = g.en;
    m_addr = g.addr;
    if (r) m_prio = 1'b0;
    else if (aacc) m_prio = 1'b1;
    else if (lacc) m_prio = 1'b0;
  endtask

  task automatic idle(input logic r);
    cyc(r, 0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; ld_valid = 0; claim_en = 0;
    alu_addr = '0; ld_addr = '0; claim_addr = '0;
    alu_val = '0; ld_val = '0;

    idle(1);
    idle(1);
    chk("rst_addr", 64'(reg_addr_w), 64'(0));
    chk("rst_val", 64'(reg_val_w), 64'(0));

    // ALU-only write
    cyc(0, 1, 4'd3, 32'hDEADBEEF, 0, '0, '0, 0, '0);
    idle(0);
    idle(0);

    // Dual contention after reset: ALU, LD, ALU, LD
    idle(1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, AW'(i + 1), RW'(32'hA000 + i),
             1, AW'(i + 8), RW'(32'hB000 + i), 0, '0);
    end
    idle(0);

    // Claim r5, then retire it
    cyc(0, 0, '0, '0, 0, '0, '0, 1, 4'd5);
    idle(0);
    cyc(0, 1, 4'd5, 32'h55, 0, '0, '0, 0, '0);
    idle(0);
    idle(0);

    // Claim r7 in the cycle its write retires
    cyc(0, 0, '0, '0, 1, 4'd7, 32'h77, 0, '0);
    cyc(0, 0, '0, '0, 0, '0, '0, 1, 4'd7);
    idle(0);

    // Reset during contention with pending bits
    cyc(0, 0, '0, '0, 0, '0, '0, 1, 4'd2);
    cyc(1, 1, 4'd4, 32'h44, 1, 4'd6, 32'h66, 1, 4'd9);
    cyc(0, 1, 4'd4, 32'h44, 1, 4'd6, 32'h66, 0, '0);
    idle(0);

    // Register 0 write and claim
    cyc(0, 1, 4'd0, 32'h1, 0, '0, '0, 1, 4'd0);
    idle(0);
    idle(0);

    for (int i = 0; i < 60; i++) begin
      cyc(($urandom_range(0, 19) == 0),
          1'($urandom), AW'($urandom), RW'($urandom),
          1'($urandom), AW'($urandom), RW'($urandom),
          1'($urandom), AW'($urandom));
    end
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
